// File: rtl/regfile_flags_32x64_if.sv
// regfile_flags_32x64_if: operand/result/flags bus between ALU control and the register file
interface regfile_flags_32x64_if #(parameter int WIDTH = 64);
  logic [4:0] A_sel, B_sel, D_sel;
  logic [WIDTH-1:0] D_in, A_out, B_out;
  logic write_en, status_load, cond_true;
  logic [3:0] status_in, cond, flags;
  modport master (
    output A_sel, B_sel, D_sel, D_in, write_en, status_in, status_load, cond,
    input A_out, B_out, flags, cond_true
  );
  modport slave (
    input A_sel, B_sel, D_sel, D_in, write_en, status_in, status_load, cond,
    output A_out, B_out, flags, cond_true
  );
endinterface

// File: rtl/regfile_flags_32x64.sv
// regfile_flags_32x64: 32x64 LEGv8 register file with XZR, optional write bypass, NZCV flags and B.cond evaluation
module regfile_flags_32x64 #(
  parameter int WIDTH  = 64,
  parameter bit BYPASS = 1'b1
) (
  input logic clock,
  input logic reset,
  regfile_flags_32x64_if.slave bus
);
  logic [WIDTH-1:0] regs [32];
  logic [3:0] flags_q;
  logic fwd, base;
  // a live write to a real register may be forwarded to the read ports
  assign fwd = BYPASS && bus.write_en && bus.D_sel != 5'd31;
  assign bus.A_out = (bus.A_sel == 5'd31) ? '0 : (fwd && bus.A_sel == bus.D_sel) ? bus.D_in : regs[bus.A_sel];
  assign bus.B_out = (bus.B_sel == 5'd31) ? '0 : (fwd && bus.B_sel == bus.D_sel) ? bus.D_in : regs[bus.B_sel];
  assign bus.flags = flags_q;
  // register writes; R31 is never written so it stays zero
  always_ff @(posedge clock or negedge reset)
    if (!reset)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (bus.write_en && bus.D_sel != 5'd31)
      regs[bus.D_sel] <= bus.D_in;
  // status latch for flag-setting ops
  always_ff @(posedge clock or negedge reset)
    if (!reset) flags_q <= '0;
    else if (bus.status_load) flags_q <= bus.status_in;
  // odd codes are the inverse of the even code below them; 111x is always
  always_comb begin
    case (bus.cond[3:1])
      3'd0:    base = flags_q[0];
      3'd1:    base = flags_q[2];
      3'd2:    base = flags_q[1];
      3'd3:    base = flags_q[3];
      3'd4:    base = flags_q[2] & ~flags_q[0];
      3'd5:    base = flags_q[1] == flags_q[3];
      3'd6:    base = ~flags_q[0] & (flags_q[1] == flags_q[3]);
      default: base = 1'b1;
    endcase
    bus.cond_true = (bus.cond[3:1] == 3'b111) ? 1'b1 : base ^ bus.cond[0];
  end
endmodule

// File: tb/tb_regfile_flags_32x64.sv
// tb_regfile_flags_32x64: scoreboard bench for the register file, flags and condition logic
module tb_regfile_flags_32x64;
  typedef struct packed {
    logic [7:0]  tag;
    logic [63:0] a, b, a0;
    logic [3:0]  f;
    logic        ct;
  } exp_t;
  logic clock = 1'b0, reset = 1'b0;
  logic [4:0] a_sel = '0, b_sel = '0, d_sel = '0;
  logic [63:0] d_in = '0;
  logic we = 1'b0, sl = 1'b0;
  logic [3:0] st = '0, cnd = '0;
  int checks = 0, failures = 0;
  exp_t q[$];
  logic [63:0] m [32];
  logic [3:0] mf;
  regfile_flags_32x64_if #(64) bus();
  regfile_flags_32x64_if #(64) bus0();
  assign bus.A_sel = a_sel;  assign bus0.A_sel = a_sel;
  assign bus.B_sel = b_sel;  assign bus0.B_sel = b_sel;
  assign bus.D_sel = d_sel;  assign bus0.D_sel = d_sel;
  assign bus.D_in = d_in;    assign bus0.D_in = d_in;
  assign bus.write_en = we;  assign bus0.write_en = we;
  assign bus.status_in = st; assign bus0.status_in = st;
  assign bus.status_load = sl; assign bus0.status_load = sl;
  assign bus.cond = cnd;     assign bus0.cond = cnd;
  regfile_flags_32x64 #(.WIDTH(64), .BYPASS(1'b1)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  regfile_flags_32x64 #(.WIDTH(64), .BYPASS(1'b0)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
  always #5 clock = ~clock;

  function automatic logic cf(input logic [3:0] f, input logic [3:0] c);
    logic v, cy, n, z;
    {v, cy, n, z} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s tag=%0d actual=%h required=%h", name, tag, act, exp);
    end
  endtask

  // monitor: outputs are presented every cycle; compare at negedge when an expectation is pending
  always @(negedge clock)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("A_out", e.tag, bus.A_out, e.a);
      chk("B_out", e.tag, bus.B_out, e.b);
      chk("A_out_nobypass", e.tag, bus0.A_out, e.a0);
      chk("flags", e.tag, {60'd0, bus.flags}, {60'd0, e.f});
      chk("cond_true", e.tag, {63'd0, bus.cond_true}, {63'd0, e.ct});
    end

  task automatic cyc(input logic [4:0] as, bs, ds, input logic [63:0] din, input logic w,
                     input logic [3:0] s, input logic l, input logic [3:0] c);
    @(posedge clock);
    #1;
    a_sel = as; b_sel = bs; d_sel = ds; d_in = din; we = w; st = s; sl = l; cnd = c;
  endtask

  task automatic e(input logic [7:0] tag, input logic [63:0] a, b, a0, input logic [3:0] f, input logic ct);
    q.push_back('{tag, a, b, a0, f, ct});
  endtask

  initial begin
    logic [63:0] ea, eb, ea0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cyc(5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 4'b0001);
      e(1, 0, 0, 0, 0, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 4'b0000); e(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 5, 64'h0123456789ABCDEF, 1, 0, 0, 4'b0001); e(2, 0, 0, 0, 0, 1);
    cyc(0, 0, 6, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0, 4'b0001); e(2, 0, 0, 0, 0, 1);
    cyc(5, 6, 0, 0, 0, 0, 0, 4'b0001); e(2, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 0, 1);
    cyc(31, 0, 31, 64'hDEAD, 1, 0, 0, 4'b0001); e(3, 0, 0, 0, 0, 1);
    cyc(31, 5, 0, 0, 0, 0, 0, 4'b0001); e(3, 0, 64'h0123456789ABCDEF, 0, 0, 1);
    cyc(7, 7, 7, 64'h55, 1, 0, 0, 4'b0001); e(4, 64'h55, 64'h55, 0, 0, 1);
    cyc(7, 7, 0, 0, 0, 0, 0, 4'b0001); e(4, 64'h55, 64'h55, 64'h55, 0, 1);
    cyc(0, 0, 0, 0, 0, 4'b1010, 1, 4'b1010); e(5, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 4'b1010); e(5, 0, 0, 0, 4'b1010, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 4'b1011); e(5, 0, 0, 0, 4'b1010, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 4'b1100); e(5, 0, 0, 0, 4'b1010, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 4'b0100); e(5, 0, 0, 0, 4'b1010, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 4'b0000); e(5, 0, 0, 0, 4'b1010, 0);
    cyc(8, 0, 8, 64'h1234, 1, 4'b0101, 1, 4'b0000); e(6, 64'h1234, 0, 0, 4'b1010, 0);
    cyc(8, 0, 0, 0, 0, 0, 0, 4'b0000); e(6, 64'h1234, 0, 64'h1234, 4'b0101, 1);
    cyc(8, 0, 0, 0, 0, 0, 0, 4'b1000); e(6, 64'h1234, 0, 64'h1234, 4'b0101, 0);
    cyc(8, 0, 0, 0, 0, 0, 0, 4'b1001); e(6, 64'h1234, 0, 64'h1234, 4'b0101, 1);
    cyc(8, 0, 0, 0, 0, 0, 0, 4'b1110); e(6, 64'h1234, 0, 64'h1234, 4'b0101, 1);
    cyc(0, 0, 3, 64'h99, 1, 0, 0, 4'b0000); e(7, 0, 0, 0, 4'b0101, 1);
    cyc(3, 0, 0, 0, 0, 0, 0, 4'b0000); e(7, 64'h99, 0, 64'h99, 4'b0101, 1);
    cyc(3, 0, 0, 0, 0, 0, 0, 4'b0000);
    #1 reset = 1'b0;
    e(7, 0, 0, 0, 0, 0);
    cyc(4, 0, 3, 64'h77, 1, 4'b1111, 1, 4'b0000); e(7, 0, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0, 0, 0, 4'b0000);
    reset = 1'b1;
    e(7, 0, 0, 0, 0, 0);
    cyc(3, 0, 3, 64'h42, 1, 0, 0, 4'b0000); e(7, 64'h42, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0, 0, 0, 4'b0000); e(7, 64'h42, 0, 64'h42, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 4'b0000);
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    e(8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) m[i] = '0;
    mf = '0;
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] as, bs, ds;
      logic [63:0] din;
      logic w, l;
      logic [3:0] s, c;
      ds = 5'($urandom_range(0, 31));
      as = ($urandom_range(0, 3) == 0) ? ds : 5'($urandom_range(0, 31));
      bs = ($urandom_range(0, 3) == 0) ? ds : 5'($urandom_range(0, 31));
      din = {$urandom, $urandom};
      w = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15));
      cyc(as, bs, ds, din, w, s, l, c);
      ea0 = (as == 31) ? 64'd0 : m[as];
      ea = (as == 31) ? 64'd0 : (w && ds == as) ? din : m[as];
      eb = (bs == 31) ? 64'd0 : (w && ds == bs) ? din : m[bs];
      e(9, ea, eb, ea0, mf, cf(mf, c));
      if (w && ds != 31) m[ds] = din;
      if (l) mf = s;
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
